btn_uart_tx: RTL and testbench
==============================

// Module: btn_uart_tx
// PURPOSE
//  Consumes the one-cycle debounced button pulse and transmits one UART frame
//  (LSB first, 8N1 by default) carrying the byte on data_in. It sits between
//  the pushbutton debouncer and the board TX pin.
//  A one-deep request buffer means a press during a frame is queued, not lost.
// PARAMETERS
//  CLK_FREQ   100_000_000  input clock frequency, Hz
//  BAUD       9600         line rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer div, >=2)
//  DATA_BITS  8            payload bits per frame (5..9)
// PORTS
//  clk       in   1          system clock, rising edge
//  rst       in   1          asynchronous reset, active-high
//  send      in   1          one-cycle request pulse from the debouncer
//  data_in   in   DATA_BITS  payload, sampled in the cycle send=1
//  tx        out  1          serial line, idle high
//  busy      out  1          high while a frame is on the line or a request is queued
//  done      out  1          one-cycle pulse in the last cycle of the stop bit
// BEHAVIOUR
//  - Reset (async, any state): tx=1, busy=0, done=0, state=IDLE, pending=0,
//    bit/baud counters=0. Reset mid-frame truncates the frame; tx goes high at once.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: send=1 captures data_in into shift reg; START entered next cycle (tx=0).
//  - Each of START/DATA bit/PARITY/STOP holds tx for exactly CLKS_PER_BIT cycles.
//    Baud counter runs 0..CLKS_PER_BIT-1 and clears on every state entry.
//  - DATA: DATA_BITS bits, LSB first; bit index 0..DATA_BITS-1, wrap goes to
//    PARITY/STOP.
//  - STOP: tx=1. done=1 in its final cycle, then IDLE. Latency: send pulse to
//    first start-bit cycle = 1 clk. Frame = (2+DATA_BITS[+1])*CLKS_PER_BIT cycles.
//  - send while not IDLE and pending=0: data_in captured into pend_reg, pending=1.
//  - send while pending=1: ignored; pend_reg is unchanged.
//  - Leaving STOP with pending=1: go directly to START, not IDLE. Load pend_reg
//    and clear pending. Frames are back-to-back; tx stays high only for the stop bit.
//  - send in the same cycle as STOP->IDLE with pending=0: treated as an IDLE
//    request. START is entered on the next cycle.
//  - busy = (state!=IDLE) | pending; it is low only in IDLE with no queue.
// CONFIGURATION
//  UART_PARITY_EN defined: a PARITY state is inserted after DATA.
//    tx = even parity (XOR of the payload bits) for CLKS_PER_BIT cycles.
//  Not defined: no PARITY state; DATA goes straight to STOP (8N1 framing).
// STRUCTURE
//  uart_pkg: tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
//    Also the function clks_per_bit(clk_freq, baud) and the width helper
//    for the baud counter ($clog2).
//  Sub-module baud_tick_gen: counter with clear input.
//    Emits a tick on count CLKS_PER_BIT-1 and wraps to 0.
// TESTING  (CLK_FREQ=1000, BAUD=100 -> CLKS_PER_BIT=10)
//  1 Reset then idle 50 cycles -> tx=1, busy=0, done=0 throughout.
//  2 send with data_in=8'hA5 -> tx low cycles 1-10, then 1,0,1,0,0,1,0,1
//    (10 cycles each), then stop high.
//    done at cycle 100; busy falls at cycle 101.
//  3 send 8'h3C, then send 8'hC3 at cycle 40 -> second frame's start bit
//    begins cycle 101. Payload 0xC3 on the line; two done pulses, 100 apart.
//  4 Three sends within one frame (0x11, 0x22, 0x33) -> only 0x11 and 0x22
//    transmitted; 0x33 dropped.
//  5 Assert rst at cycle 45 of a frame -> tx=1 and busy=0 asynchronously.
//    No done; next send starts a clean frame.
//  6 UART_PARITY_EN, send 8'h07 -> parity bit 1 after data.
//    Frame 110 cycles; done at cycle 110.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and sizing helpers for the button-driven UART transmitter.
// Holds the FSM state enum, the baud-divide computation and the counter width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period counter: ticks on count CLKS_PER_BIT-1 and wraps to 0; clr forces 0.
// Latency: tick is combinational from the count; no backpressure.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = cnt_width(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/btn_uart_tx.sv
// One UART frame (LSB first) per button pulse, with a one-deep queue for presses mid-frame.
// Latency: send to start bit = 1 clk; busy covers frame plus queue. Optional macro UART_PARITY_EN adds even parity.
module btn_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD      = 9600,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int BIT_W = cnt_width(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  tx_state_t             state, state_nxt;
  logic [DATA_BITS-1:0]  shift_reg;
  logic [DATA_BITS-1:0]  pend_reg;
  logic                  pending;
  logic [BIT_W-1:0]      bit_idx;
  logic                  tick;
  logic                  baud_clr;

  logic load_new;
  logic load_pend;
  logic capture_pend;
  logic shift_en;
  logic bit_inc;
  logic bit_clr;

`ifdef UART_PARITY_EN
  logic par_reg;
`endif

  // Counter restarts on every state entry and is parked at zero while idle.
  assign baud_clr = (state == IDLE) || (state_nxt != state);

  baud_tick_gen #(
    .CLKS_PER_BIT(CPB)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    load_new     = 1'b0;
    load_pend    = 1'b0;
    shift_en     = 1'b0;
    bit_inc      = 1'b0;
    bit_clr      = 1'b0;
    tx           = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        if (send) begin
          state_nxt = START;
          load_new  = 1'b1;
        end
      end
      START: begin
        tx = 1'b0;
        if (tick) state_nxt = DATA;
      end
      DATA: begin
        tx = shift_reg[0];
        if (tick) begin
          shift_en = 1'b1;
          if (bit_idx == LAST_BIT) begin
            bit_clr = 1'b1;
`ifdef UART_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_inc = 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef UART_PARITY_EN
        tx = par_reg;
`endif
        if (tick) state_nxt = STOP;
      end
      STOP: begin
        if (tick) begin
          done = 1'b1;
          // Queued request wins; otherwise a press landing now is handled as a fresh idle request.
          if (pending) begin
            state_nxt = START;
            load_pend = 1'b1;
          end else if (send) begin
            state_nxt = START;
            load_new  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign capture_pend = send && (state != IDLE) && !pending && !load_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
    end else if (load_new) begin
      shift_reg <= data_in;
    end else if (load_pend) begin
      shift_reg <= pend_reg;
    end else if (shift_en) begin
      shift_reg <= {1'b0, shift_reg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_reg <= 1'b0;
    end else if (load_new) begin
      par_reg <= ^data_in;
    end else if (load_pend) begin
      par_reg <= ^pend_reg;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= 1'b0;
      pend_reg <= '0;
    end else if (load_pend) begin
      pending <= 1'b0;
    end else if (capture_pend) begin
      pending  <= 1'b1;
      pend_reg <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx <= '0;
    end else if (bit_clr || state == IDLE) begin
      bit_idx <= '0;
    end else if (bit_inc) begin
      bit_idx <= bit_idx + BIT_W'(1);
    end
  end

  assign busy = (state != IDLE) || pending;

endmodule

// File: tb/tb_btn_uart_tx.sv
// Directed bench for btn_uart_tx at CLKS_PER_BIT=10; cycle k counts clocks after the send cycle.
module tb_btn_uart_tx;

  localparam int CPB = 10;
`ifdef UART_PARITY_EN
  localparam int NSLOT = 11;
`else
  localparam int NSLOT = 10;
`endif
  localparam int FRAME = NSLOT * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx;
  logic       busy;
  logic       done;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  btn_uart_tx #(
    .CLK_FREQ (1000),
    .BAUD     (100),
    .DATA_BITS(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .send   (send),
    .data_in(data_in),
    .tx     (tx),
    .busy   (busy),
    .done   (done)
  );

  // Expected line level in cycle c (1-based) of a frame carrying d.
  function automatic logic exp_bit(input logic [7:0] d, input int c);
    int slot;
    if (c < 1 || c > FRAME) return 1'b1;
    slot = (c - 1) / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[slot-1];
`ifdef UART_PARITY_EN
    if (slot == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    send = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_state: tx=%b busy=%b done=%b, want 1/0/0", tx, busy, done);
    else pass_cnt++;
    rst = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL idle c=%0d: tx=%b busy=%b done=%b, want 1/0/0", c, tx, busy, done);
      else pass_cnt++;
    end
  endtask

  task automatic test_single(input logic [7:0] d);
    @(negedge clk);
    send = 1'b1;
    data_in = d;
    for (int c = 1; c <= FRAME + 1; c++) begin
      @(negedge clk);
      send = 1'b0;
      chk_cnt++;
      if (tx !== exp_bit(d, c))
        $display("FAIL single_tx d=%h c=%0d: tx=%b want %b", d, c, tx, exp_bit(d, c));
      else pass_cnt++;
      chk_cnt++;
      if (done !== (c == FRAME))
        $display("FAIL single_done d=%h c=%0d: done=%b want %b", d, c, done, (c == FRAME));
      else pass_cnt++;
      chk_cnt++;
      if (busy !== (c <= FRAME))
        $display("FAIL single_busy d=%h c=%0d: busy=%b want %b", d, c, busy, (c <= FRAME));
      else pass_cnt++;
    end
  endtask

  // Frame d1 sent at cycle 0; extra sends happen at cycles s2 (d2) and s3 (d3, if s3>0).
  task automatic run_two(input string name, input logic [7:0] d1, input logic [7:0] d2,
                         input int s2, input logic [7:0] d3, input int s3);
    logic e;
    @(negedge clk);
    send = 1'b1;
    data_in = d1;
    for (int c = 1; c <= 2 * FRAME + 20; c++) begin
      @(negedge clk);
      send = 1'b0;
      e = (c <= FRAME) ? exp_bit(d1, c) : exp_bit(d2, c - FRAME);
      chk_cnt++;
      if (tx !== e)
        $display("FAIL %s_tx c=%0d: tx=%b want %b", name, c, tx, e);
      else pass_cnt++;
      chk_cnt++;
      if (done !== (c == FRAME || c == 2 * FRAME))
        $display("FAIL %s_done c=%0d: done=%b want %b", name, c, done, (c == FRAME || c == 2 * FRAME));
      else pass_cnt++;
      chk_cnt++;
      if (busy !== (c <= 2 * FRAME))
        $display("FAIL %s_busy c=%0d: busy=%b want %b", name, c, busy, (c <= 2 * FRAME));
      else pass_cnt++;
      if (c == s2) begin
        send = 1'b1;
        data_in = d2;
      end else if (s3 > 0 && c == s3) begin
        send = 1'b1;
        data_in = d3;
      end
    end
  endtask

  task automatic test_back_to_back();
    run_two("queue", 8'h3C, 8'hC3, 40, 8'h00, 0);
  endtask

  task automatic test_drop();
    run_two("drop", 8'h11, 8'h22, 20, 8'h33, 50);
  endtask

  task automatic test_stop_edge_send();
    run_two("stopedge", 8'hAA, 8'h55, FRAME, 8'h00, 0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    send = 1'b1;
    data_in = 8'h5A;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      send = 1'b0;
      chk_cnt++;
      if (tx !== exp_bit(8'h5A, c))
        $display("FAIL rstmid_tx c=%0d: tx=%b want %b", c, tx, exp_bit(8'h5A, c));
      else pass_cnt++;
    end
    rst = 1'b1;
    #1;
    chk_cnt++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_async: tx=%b busy=%b done=%b, want 1/0/0", tx, busy, done);
    else pass_cnt++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_cnt++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
        $display("FAIL rstmid_hold c=%0d: tx=%b busy=%b done=%b, want 1/0/0", c, tx, busy, done);
      else pass_cnt++;
    end
    rst = 1'b0;
    @(negedge clk);
    test_single(8'h96);
  endtask

  task automatic test_parity();
    @(negedge clk);
    send = 1'b1;
    data_in = 8'h07;
    for (int c = 1; c <= FRAME + 1; c++) begin
      @(negedge clk);
      send = 1'b0;
      chk_cnt++;
      if (tx !== exp_bit(8'h07, c))
        $display("FAIL parity_tx c=%0d: tx=%b want %b", c, tx, exp_bit(8'h07, c));
      else pass_cnt++;
`ifdef UART_PARITY_EN
      if (c == 95) begin
        chk_cnt++;
        if (tx !== 1'b1) $display("FAIL parity_bit: tx=%b want 1", tx);
        else pass_cnt++;
      end
`endif
      chk_cnt++;
      if (done !== (c == FRAME))
        $display("FAIL parity_done c=%0d: done=%b want %b", c, done, (c == FRAME));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_back_to_back();
    test_drop();
    test_stop_edge_send();
    test_reset_mid();
    test_parity();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
